// File: rtl/sfa_control_nch.sv
// N-channel SFA command controller: decodes AXI-Stream commands into per-channel BIF config, launches channels, returns one completion word.
// Optional RUN-state watchdog is compiled in with `define SFA_TIMEOUT_EN.
module sfa_control_nch #(
    parameter int NUM_BC      = 2,
    parameter int FIELD_W     = 24,
    parameter int NUM_CONF    = 6,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    output logic                        sCMD_tready,
    input  logic                        sCMD_tvalid,
    input  logic [31:0]                 sCMD_tdata,
    input  logic                        mRet_tready,
    output logic                        mRet_tvalid,
    output logic [31:0]                 mRet_tdata,
    output logic [NUM_BC-1:0]           BC_ap_start,
    input  logic [NUM_BC-1:0]           BC_ap_done,
    input  logic [NUM_BC-1:0]           BC_ap_idle,
    output logic [NUM_BC-1:0]           BC_MODE,
    output logic [NUM_BC*FIELD_W-1:0]   BC_INDEX,
    output logic [NUM_BC*FIELD_W-1:0]   BC_SIZE,
    output logic [NUM_BC*FIELD_W-1:0]   BC_STRIDE,
    output logic [NUM_CONF*4-1:0]       CONF
);
    typedef enum logic [2:0] {FETCH, DECODE, WAIT_IDLE, RUN, WRITE_BACK} state_t;

    state_t                           state_q, state_d;
    logic [31:0]                      cmd_q, cmd_d;
    logic [31:0]                      ret_q, ret_d;
    logic [NUM_BC-1:0]                mode_q, mode_d;
    logic [NUM_BC-1:0][FIELD_W-1:0]   index_q, index_d;
    logic [NUM_BC-1:0][FIELD_W-1:0]   size_q, size_d;
    logic [NUM_BC-1:0][FIELD_W-1:0]   stride_q, stride_d;
    logic [NUM_CONF*4-1:0]            conf_q, conf_d;
    logic [NUM_BC-1:0]                mask_q, mask_d;
    logic [NUM_BC-1:0]                sticky_q, sticky_d;
    logic [NUM_BC-1:0]                start_q, start_d;
    logic [NUM_BC-1:0]                done_now;
    logic [3:0]                       op, ch;
    logic [7:0]                       idle8, sticky8;
`ifdef SFA_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
    logic [31:0]                      cnt_q, cnt_d;
`endif

    assign op = cmd_q[31:28];
    assign ch = cmd_q[27:24];
    // Done is only meaningful from the cycle after the start pulse.
    assign done_now = BC_ap_done & mask_q & ~start_q;

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        ret_d    = ret_q;
        mode_d   = mode_q;
        index_d  = index_q;
        size_d   = size_q;
        stride_d = stride_q;
        conf_d   = conf_q;
        mask_d   = mask_q;
        sticky_d = sticky_q;
        start_d  = '0;
        idle8    = '0;
        idle8[NUM_BC-1:0] = BC_ap_idle;
        sticky8  = '0;
`ifdef SFA_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            FETCH: begin
                if (sCMD_tvalid) begin
                    cmd_d   = sCMD_tdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = FETCH;
                case (op)
                    4'h1: conf_d = cmd_q[NUM_CONF*4-1:0];
                    4'h2, 4'h3, 4'h4, 4'h5: begin
                        // Out-of-range channels match no k and fall through untouched.
                        for (int k = 0; k < NUM_BC; k++) begin
                            if (ch == 4'(k)) begin
                                if (op == 4'h2) mode_d[k]   = cmd_q[0];
                                if (op == 4'h3) index_d[k]  = cmd_q[FIELD_W-1:0];
                                if (op == 4'h4) size_d[k]   = cmd_q[FIELD_W-1:0];
                                if (op == 4'h5) stride_d[k] = cmd_q[FIELD_W-1:0];
                            end
                        end
                    end
                    4'hA: begin
                        mask_d = cmd_q[NUM_BC-1:0];
                        if (cmd_q[NUM_BC-1:0] == '0) begin
                            ret_d   = 32'hE000_0000;
                            state_d = WRITE_BACK;
                        end else begin
                            state_d = WAIT_IDLE;
                        end
                    end
                    4'hB: begin
                        ret_d   = {16'hB000, 8'h00, idle8};
                        state_d = WRITE_BACK;
                    end
                    default: ;
                endcase
            end
            WAIT_IDLE: begin
                if ((BC_ap_idle & mask_q) == mask_q) begin
                    start_d  = mask_q;
                    sticky_d = '0;
                    state_d  = RUN;
`ifdef SFA_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            RUN: begin
                sticky_d = sticky_q | done_now;
                sticky8[NUM_BC-1:0] = sticky_d;
                if (sticky_d == mask_q) begin
                    ret_d   = 32'h0000_FFFF;
                    state_d = WRITE_BACK;
                end
`ifdef SFA_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    ret_d   = {16'hDEAD, 8'h00, sticky8};
                    state_d = WRITE_BACK;
                end
                cnt_d = cnt_q + 32'd1;
`endif
            end
            WRITE_BACK: begin
                if (mRet_tready) begin
                    sticky_d = '0;
                    state_d  = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= FETCH;
            cmd_q    <= '0;
            ret_q    <= '0;
            mode_q   <= '0;
            index_q  <= '0;
            size_q   <= '0;
            stride_q <= '0;
            conf_q   <= '0;
            mask_q   <= '0;
            sticky_q <= '0;
            start_q  <= '0;
`ifdef SFA_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            ret_q    <= ret_d;
            mode_q   <= mode_d;
            index_q  <= index_d;
            size_q   <= size_d;
            stride_q <= stride_d;
            conf_q   <= conf_d;
            mask_q   <= mask_d;
            sticky_q <= sticky_d;
            start_q  <= start_d;
`ifdef SFA_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign sCMD_tready = (state_q == FETCH);
    assign mRet_tvalid = (state_q == WRITE_BACK);
    assign mRet_tdata  = ret_q;
    assign BC_ap_start = start_q;
    assign BC_MODE     = mode_q;
    assign BC_INDEX    = index_q;
    assign BC_SIZE     = size_q;
    assign BC_STRIDE   = stride_q;
    assign CONF        = conf_q;
endmodule

// File: tb/tb_sfa_control_nch.sv
// Self-checking bench for sfa_control_nch (NUM_BC=2); expected return words are queued when commands are sent.
module tb_sfa_control_nch;
    localparam int NUM_BC = 2;
    localparam int FW     = 24;
    localparam int NC     = 6;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              sCMD_tready, sCMD_tvalid = 1'b0;
    logic [31:0]       sCMD_tdata = '0;
    logic              mRet_tready = 1'b0, mRet_tvalid;
    logic [31:0]       mRet_tdata;
    logic [NUM_BC-1:0] BC_ap_start, BC_ap_done = '0, BC_ap_idle = '0, BC_MODE;
    logic [NUM_BC*FW-1:0] BC_INDEX, BC_SIZE, BC_STRIDE;
    logic [NC*4-1:0]   CONF;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    sfa_control_nch #(.NUM_BC(NUM_BC), .FIELD_W(FW), .NUM_CONF(NC), .TIMEOUT_CYC(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .sCMD_tready(sCMD_tready), .sCMD_tvalid(sCMD_tvalid), .sCMD_tdata(sCMD_tdata),
        .mRet_tready(mRet_tready), .mRet_tvalid(mRet_tvalid), .mRet_tdata(mRet_tdata),
        .BC_ap_start(BC_ap_start), .BC_ap_done(BC_ap_done), .BC_ap_idle(BC_ap_idle),
        .BC_MODE(BC_MODE), .BC_INDEX(BC_INDEX), .BC_SIZE(BC_SIZE), .BC_STRIDE(BC_STRIDE),
        .CONF(CONF)
    );

    always #5 ACLK = ~ACLK;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Returns #1 after the accepting edge (DUT then sits in DECODE).
    task automatic send_cmd(input logic [31:0] w);
        int n = 0;
        sCMD_tdata  = w;
        sCMD_tvalid = 1'b1;
        while (!sCMD_tready && n < 40) begin
            step();
            n++;
        end
        if (!sCMD_tready) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout: tready=%b required 1 for cmd %h", sCMD_tready, w);
        end else begin
            step();
        end
        sCMD_tvalid = 1'b0;
    endtask

    task automatic collect_ret(input int max_wait);
        int n = 0;
        logic [31:0] exp;
        while (!mRet_tvalid && n < max_wait) begin
            step();
            n++;
        end
        checks++;
        if (!mRet_tvalid) begin
            errors++;
            $display("FAIL ret_timeout: tvalid=%b required 1 within %0d cycles", mRet_tvalid, max_wait);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ret_unexpected: got %h required no return", mRet_tdata);
        end else begin
            exp = exp_q.pop_front();
            if (mRet_tdata !== exp) begin
                errors++;
                $display("FAIL ret_data: got %h required %h", mRet_tdata, exp);
            end
            mRet_tready = 1'b1;
            step();
            mRet_tready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({sCMD_tready, mRet_tvalid, BC_ap_start, BC_MODE} !== {1'b1, 1'b0, 2'b00, 2'b00} ||
            BC_INDEX !== '0 || BC_SIZE !== '0 || BC_STRIDE !== '0 || CONF !== '0 || mRet_tdata !== '0) begin
            errors++;
            $display("FAIL reset_state: tready=%b tvalid=%b start=%b idx=%h conf=%h ret=%h required 1/0/0/0/0/0",
                     sCMD_tready, mRet_tvalid, BC_ap_start, BC_INDEX, CONF, mRet_tdata);
        end
        step();
        ARESET = 1'b0;
        step();
    endtask

    task automatic test_config();
        send_cmd(32'h3100_0123);
        checks++;
        if (sCMD_tready !== 1'b0) begin
            errors++; $display("FAIL tready_decode: got %b required 0", sCMD_tready);
        end
        step();
        checks++;
        if (sCMD_tready !== 1'b1) begin
            errors++; $display("FAIL tready_return: got %b required 1", sCMD_tready);
        end
        send_cmd(32'h4000_0040); step();
        send_cmd(32'h2100_0001); step();
        send_cmd(32'h5000_0007); step();
        send_cmd(32'h10AB_CDEF); step();
        checks++;
        if (BC_INDEX !== {24'h000123, 24'h0} || BC_SIZE !== {24'h0, 24'h000040}) begin
            errors++; $display("FAIL index_size: idx=%h size=%h required 000123000000/000000000040", BC_INDEX, BC_SIZE);
        end
        checks++;
        if (BC_MODE !== 2'b10 || BC_STRIDE !== {24'h0, 24'h000007}) begin
            errors++; $display("FAIL mode_stride: mode=%b stride=%h required 10/000000000007", BC_MODE, BC_STRIDE);
        end
        checks++;
        if (CONF !== 24'hABCDEF) begin
            errors++; $display("FAIL conf: got %h required abcdef", CONF);
        end
    endtask

    task automatic test_start_both();
        BC_ap_idle = 2'b11;
        exp_q.push_back(32'h0000_FFFF);
        send_cmd(32'hA000_0003);
        step();
        checks++;
        if (BC_ap_start !== 2'b00) begin
            errors++; $display("FAIL start_early: got %b required 00", BC_ap_start);
        end
        step();
        checks++;
        if (BC_ap_start !== 2'b11) begin
            errors++; $display("FAIL start_pulse: got %b required 11", BC_ap_start);
        end
        for (int k = 1; k <= 7; k++) begin
            step();
            BC_ap_done = (k == 3) ? 2'b01 : (k == 7) ? 2'b10 : 2'b00;
            checks++;
            if (BC_ap_start !== 2'b00 || mRet_tvalid !== 1'b0) begin
                errors++; $display("FAIL run_k%0d: start=%b tvalid=%b required 00/0", k, BC_ap_start, mRet_tvalid);
            end
        end
        step();
        BC_ap_done = 2'b00;
        for (int h = 0; h < 3; h++) begin
            checks++;
            if (mRet_tvalid !== 1'b1 || mRet_tdata !== 32'h0000_FFFF) begin
                errors++; $display("FAIL ret_hold%0d: tvalid=%b data=%h required 1/0000ffff", h, mRet_tvalid, mRet_tdata);
            end
            step();
        end
        collect_ret(2);
    endtask

    task automatic test_wait_idle();
        BC_ap_idle = 2'b10;
        exp_q.push_back(32'h0000_FFFF);
        send_cmd(32'hA000_0001);
        for (int k = 0; k < 5; k++) begin
            step();
            BC_ap_done = 2'b10;
            checks++;
            if (BC_ap_start !== 2'b00) begin
                errors++; $display("FAIL no_start_busy%0d: got %b required 00", k, BC_ap_start);
            end
        end
        BC_ap_done = 2'b00;
        BC_ap_idle = 2'b11;
        step();
        checks++;
        if (BC_ap_start !== 2'b01) begin
            errors++; $display("FAIL start_mask01: got %b required 01", BC_ap_start);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            BC_ap_done = 2'b10;
            checks++;
            if (mRet_tvalid !== 1'b0) begin
                errors++; $display("FAIL unmasked_done%0d: tvalid=%b required 0", k, mRet_tvalid);
            end
        end
        BC_ap_done = 2'b01;
        step();
        BC_ap_done = 2'b00;
        collect_ret(3);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (mRet_tvalid !== 1'b0) begin
                errors++; $display("FAIL single_ret%0d: tvalid=%b required 0", k, mRet_tvalid);
            end
        end
    endtask

    task automatic test_edge_cmds();
        exp_q.push_back(32'hE000_0000);
        send_cmd(32'hA000_0000);
        step();
        checks++;
        if (mRet_tvalid !== 1'b1 || BC_ap_start !== 2'b00) begin
            errors++; $display("FAIL mask0_ret: tvalid=%b start=%b required 1/00", mRet_tvalid, BC_ap_start);
        end
        collect_ret(1);
        send_cmd(32'h35AB_CDEF); step();
        send_cmd(32'h4200_0099); step();
        send_cmd(32'h7000_1234); step();
        checks++;
        if (BC_INDEX !== {24'h000123, 24'h0} || BC_SIZE !== {24'h0, 24'h000040} || CONF !== 24'hABCDEF) begin
            errors++; $display("FAIL bad_ch_nochange: idx=%h size=%h conf=%h required unchanged", BC_INDEX, BC_SIZE, CONF);
        end
        BC_ap_idle = 2'b10;
        exp_q.push_back(32'hB000_0002);
        send_cmd(32'hB000_0000);
        collect_ret(3);
    endtask

    task automatic test_reset_run();
        BC_ap_idle = 2'b11;
        send_cmd(32'hA000_0003);
        step();
        step();
        #2;
        ARESET = 1'b1;
        #1;
        checks++;
        if (BC_ap_start !== 2'b00 || sCMD_tready !== 1'b1 || mRet_tvalid !== 1'b0 ||
            BC_INDEX !== '0 || BC_SIZE !== '0 || BC_MODE !== '0 || CONF !== '0 || mRet_tdata !== '0) begin
            errors++; $display("FAIL reset_mid_run: start=%b tready=%b idx=%h conf=%h required 00/1/0/0",
                               BC_ap_start, sCMD_tready, BC_INDEX, CONF);
        end
        step();
        ARESET = 1'b0;
        for (int k = 0; k < 3; k++) begin
            BC_ap_done = 2'b11;
            step();
            checks++;
            if (mRet_tvalid !== 1'b0 || sCMD_tready !== 1'b1) begin
                errors++; $display("FAIL post_reset_done%0d: tvalid=%b tready=%b required 0/1", k, mRet_tvalid, sCMD_tready);
            end
        end
        BC_ap_done = 2'b00;
    endtask

`ifdef SFA_TIMEOUT_EN
    task automatic test_timeout();
        BC_ap_idle = 2'b11;
        exp_q.push_back(32'hDEAD_0001);
        send_cmd(32'hA000_0003);
        step();
        step();
        for (int k = 1; k <= 15; k++) begin
            step();
            BC_ap_done = (k == 2) ? 2'b01 : 2'b00;
            checks++;
            if (mRet_tvalid !== 1'b0) begin
                errors++; $display("FAIL timeout_early%0d: tvalid=%b required 0", k, mRet_tvalid);
            end
        end
        step();
        BC_ap_done = 2'b00;
        checks++;
        if (mRet_tvalid !== 1'b1) begin
            errors++; $display("FAIL timeout_fire: tvalid=%b required 1", mRet_tvalid);
        end
        collect_ret(2);
    endtask
`endif

    initial begin
        test_reset();
        test_config();
        test_start_both();
        test_wait_idle();
        test_edge_cmds();
        test_reset_run();
`ifdef SFA_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d returns outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
